mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 16-bit pipelined core, between the EX/MEM and MEM/WB pipeline registers. It drives a variable-latency data memory over a req/ack handshake and freezes the upstream pipeline with `stall` while an access is outstanding. It inserts bubbles toward MEM/WB during stalls and forwards the MEM/WB writeback value into store data.

## Interface
Parameters
- `WORD_W`, 16: datapath/address width
- `RAW`, 4: register-address width

Ports
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `EXMEMalu_out`  in  16  ALU result / memory byte address
- `EXMEMstore_data`  in  16  rt register value for SW
- `EXMEMrt`  in  4  source register of store data
- `EXMEMrd`, `EXMEMpc`  in  4 / 16  destination reg, PC+2
- `EXMEMMemRead`, `EXMEMMemWrite`  in  1  memory op controls
- `EXMEMRegDst`, `EXMEMBranch`, `EXMEMMemtoReg`, `EXMEMALUSrc`, `EXMEMRegWrite`, `EXMEMBranchReg`, `EXMEMPCS`, `EXMEMHLT`, `EXMEMLB`  in  1  pass-through controls
- `MEMWBRegWrite`, `MEMWBMemtoReg`  in  1  writeback-stage controls
- `MEMWBrd`  in  4  writeback destination
- `MEMWBwb_data`  in  16  final writeback value
- `mem_ack`  in  1  memory completion, one-cycle pulse
- `mem_rdata`  in  16  read data, valid with `mem_ack`
- `mem_req`, `mem_we`  out  1  request level, write-enable (registered)
- `mem_addr`, `mem_wdata`  out  16  registered address / write data
- `stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- `alu_out`, `dmem_out`, `pc`, `rd`  out  16/16/16/4  to MEM/WB
- `RegDst`, `Branch`, `MemtoReg`, `ALUSrc`, `RegWrite`, `BranchReg`, `PCS`, `HLT`, `LB`  out  1  to MEM/WB

## Operation
- `memop` = `EXMEMMemRead | EXMEMMemWrite`. The upstream EX/MEM holds its contents stable while `stall`=1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, `memop`=0: all fields pass through combinationally; `dmem_out`=0; `stall`=0.
  - IDLE, `memop`=1: `stall`=1 and bubble out. Next edge: `mem_req`←1, `mem_we`←`EXMEMMemWrite`, `mem_addr`←`EXMEMalu_out`, `mem_wdata`←forwarded store data; go BUSY.
  - BUSY: `stall`=1, bubble out, request held stable. On `mem_ack`: `mem_req`←0, `mem_we`←0, read-data register ←`mem_rdata` (writes: ←0); go DONE.
  - DONE: `stall`=0. EX/MEM fields pass through; `dmem_out`=read-data register. Next edge: go IDLE.
- Bubble: `RegWrite`, `MemtoReg`, `HLT`, `Branch`, `BranchReg`, `PCS`, `LB` forced 0. Data fields pass through unchanged.
- Store forwarding rule, evaluated in IDLE:
  - Condition: `MEMWBRegWrite & MEMWBMemtoReg & (MEMWBrd==EXMEMrt) & (EXMEMrt!=0)`.
  - If true, use `MEMWBwb_data`; otherwise use `EXMEMstore_data`.
  - Captured once at launch, because MEM/WB receives bubbles afterward.
- `mem_ack` in IDLE or DONE is ignored, with no state change.
- `mem_rdata` is sampled only on `mem_ack` in BUSY.

## Timing
- Reset (`rst`=0, async):
  - State IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, read-data register=0.
  - Combinational outputs follow IDLE rules.
- Non-memory op: 0-cycle latency, no stall.
- Memory op arrives in cycle 0 (IDLE). `mem_req` is high from cycle 1 until the ack cycle, inclusive.
  - Ack in cycle k≥1 gives DONE in cycle k+1; MEM/WB captures the result at the end of k+1.
  - Minimum: 2 stall cycles (0, 1), ack in cycle 1, result in cycle 2.
- Back-to-back memory ops: DONE→IDLE. The next op launches from IDLE, with its request one cycle after DONE at earliest.
- `rst` asserted mid-access: `mem_req` drops immediately. The memory must abandon the transaction, and any later ack is ignored.
- A HLT that follows a pending memory op reaches MEM/WB only after DONE.

## Structure
- Shared `cpu_pkg`: `WORD_W`, `RAW`, state enum `mem_state_t` {IDLE, BUSY, DONE}, bubble control constant.
- One sub-module, `mem_store_fwd`: combinational forwarding comparator/mux, reusable by the EX-stage forwarding unit.
- Top: FSM, request registers, read-data register, output bubble mux.

## Test plan
- ALU op, `EXMEMalu_out`=0x1234, `RegWrite`=1 → same-cycle `alu_out`=0x1234, `RegWrite`=1, `stall`=0, `mem_req` never rises.
- LW addr 0x0040, ack in cycle 1 with rdata 0xBEEF → `stall`=1 in cycles 0–1; `mem_req`=1 in cycle 1 only; cycle 2 `dmem_out`=0xBEEF, `MemtoReg`=1, `RegWrite`=1.
- SW addr 0x0010, data 0x00AA, ack delayed to cycle 5 → `mem_we`=1 and `mem_addr`/`mem_wdata` stable in cycles 1–5; `RegWrite`=0 at MEM/WB in cycles 0–5; DONE in cycle 6.
- LW r3 in MEM/WB with `MEMWBwb_data`=0x5A5A, SW with `EXMEMrt`=3 and stale data 0x0000 → `mem_wdata`=0x5A5A. With `EXMEMrt`=0, no forwarding.
- `rst` low in cycle 2 of a BUSY read, then ack pulse → `mem_req`=0 immediately, state IDLE, ack ignored, `dmem_out`=0.
- Spurious `mem_ack` in IDLE with a non-memory op → no state change, `stall`=0, read-data register unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath widths, MEM-stage FSM states, writeback control bundle.
// Pure types and constants; no latency, no flow control.
// Bubbles are expressed by zeroing the wb_ctrl_t bundle.
package cpu_pkg;

    localparam int WORD_W = 16;
    localparam int RAW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Controls that must be squashed when MEM/WB receives a bubble.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic hlt;
        logic branch;
        logic branch_reg;
        logic pcs;
        logic lb;
    } wb_ctrl_t;

    localparam wb_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/mem_store_fwd.sv
// Store-data forwarding: picks the MEM/WB load result over stale rt data for a store.
// Purely combinational, 0-cycle latency.
// No flow control; the caller decides when the result is sampled.
module mem_store_fwd #(
    parameter int WORD_W = cpu_pkg::WORD_W,
    parameter int RAW    = cpu_pkg::RAW
) (
    input  logic              wb_reg_write,
    input  logic              wb_mem_to_reg,
    input  logic [RAW-1:0]    wb_rd,
    input  logic [WORD_W-1:0] wb_data,
    input  logic [RAW-1:0]    ex_rt,
    input  logic [WORD_W-1:0] ex_store_data,
    output logic [WORD_W-1:0] store_data
);

    logic hit;

    // r0 is hardwired zero, so a write to it must never be forwarded.
    assign hit = wb_reg_write & wb_mem_to_reg & (wb_rd == ex_rt) & (ex_rt != '0);

    assign store_data = hit ? wb_data : ex_store_data;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: launches data-memory req/ack transactions and bubbles MEM/WB meanwhile.
// Non-memory ops: 0 cycles; memory ops: result in the cycle after ack (min 2 stall cycles).
// Holds the upstream pipeline with stall from launch until ack; ack outside BUSY is ignored.
module mem_stage #(
    parameter int WORD_W = cpu_pkg::WORD_W,
    parameter int RAW    = cpu_pkg::RAW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] EXMEMalu_out,
    input  logic [WORD_W-1:0] EXMEMstore_data,
    input  logic [RAW-1:0]    EXMEMrt,
    input  logic [RAW-1:0]    EXMEMrd,
    input  logic [WORD_W-1:0] EXMEMpc,
    input  logic              EXMEMMemRead,
    input  logic              EXMEMMemWrite,
    input  logic              EXMEMRegDst,
    input  logic              EXMEMBranch,
    input  logic              EXMEMMemtoReg,
    input  logic              EXMEMALUSrc,
    input  logic              EXMEMRegWrite,
    input  logic              EXMEMBranchReg,
    input  logic              EXMEMPCS,
    input  logic              EXMEMHLT,
    input  logic              EXMEMLB,
    input  logic              MEMWBRegWrite,
    input  logic              MEMWBMemtoReg,
    input  logic [RAW-1:0]    MEMWBrd,
    input  logic [WORD_W-1:0] MEMWBwb_data,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              stall,
    output logic [WORD_W-1:0] alu_out,
    output logic [WORD_W-1:0] dmem_out,
    output logic [WORD_W-1:0] pc,
    output logic [RAW-1:0]    rd,
    output logic              RegDst,
    output logic              Branch,
    output logic              MemtoReg,
    output logic              ALUSrc,
    output logic              RegWrite,
    output logic              BranchReg,
    output logic              PCS,
    output logic              HLT,
    output logic              LB
);

    import cpu_pkg::mem_state_t;
    import cpu_pkg::wb_ctrl_t;
    import cpu_pkg::CTRL_BUBBLE;
    import cpu_pkg::IDLE;
    import cpu_pkg::BUSY;
    import cpu_pkg::DONE;

    mem_state_t        state_q, state_d;
    logic              memop;
    logic              launch;
    logic              bubble;
    logic [WORD_W-1:0] fwd_store_data;
    logic [WORD_W-1:0] rdata_q;
    wb_ctrl_t          ctrl_in, ctrl_out;

    assign memop = EXMEMMemRead | EXMEMMemWrite;

    mem_store_fwd #(
        .WORD_W (WORD_W),
        .RAW    (RAW)
    ) u_store_fwd (
        .wb_reg_write  (MEMWBRegWrite),
        .wb_mem_to_reg (MEMWBMemtoReg),
        .wb_rd         (MEMWBrd),
        .wb_data       (MEMWBwb_data),
        .ex_rt         (EXMEMrt),
        .ex_store_data (EXMEMstore_data),
        .store_data    (fwd_store_data)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stall   = 1'b1;
                    bubble  = 1'b1;
                    launch  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall  = 1'b1;
                bubble = 1'b1;
                if (mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Store data is captured at launch: MEM/WB holds only bubbles once we stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else if (launch) begin
            mem_req   <= 1'b1;
            mem_we    <= EXMEMMemWrite;
            mem_addr  <= EXMEMalu_out;
            mem_wdata <= fwd_store_data;
        end else if (state_q == BUSY && mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            rdata_q <= mem_we ? '0 : mem_rdata;
        end
    end

    assign ctrl_in = '{
        reg_write:  EXMEMRegWrite,
        mem_to_reg: EXMEMMemtoReg,
        hlt:        EXMEMHLT,
        branch:     EXMEMBranch,
        branch_reg: EXMEMBranchReg,
        pcs:        EXMEMPCS,
        lb:         EXMEMLB
    };

    assign ctrl_out = bubble ? CTRL_BUBBLE : ctrl_in;

    assign RegWrite  = ctrl_out.reg_write;
    assign MemtoReg  = ctrl_out.mem_to_reg;
    assign HLT       = ctrl_out.hlt;
    assign Branch    = ctrl_out.branch;
    assign BranchReg = ctrl_out.branch_reg;
    assign PCS       = ctrl_out.pcs;
    assign LB        = ctrl_out.lb;

    assign RegDst   = EXMEMRegDst;
    assign ALUSrc   = EXMEMALUSrc;
    assign alu_out  = EXMEMalu_out;
    assign pc       = EXMEMpc;
    assign rd       = EXMEMrd;
    assign dmem_out = (state_q == DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected memory results queued at issue, popped when the stage completes.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] EXMEMalu_out = '0, EXMEMstore_data = '0, EXMEMpc = '0;
    logic [3:0]  EXMEMrt = '0, EXMEMrd = '0;
    logic        EXMEMMemRead = 0, EXMEMMemWrite = 0, EXMEMRegDst = 0, EXMEMBranch = 0;
    logic        EXMEMMemtoReg = 0, EXMEMALUSrc = 0, EXMEMRegWrite = 0, EXMEMBranchReg = 0;
    logic        EXMEMPCS = 0, EXMEMHLT = 0, EXMEMLB = 0;
    logic        MEMWBRegWrite = 0, MEMWBMemtoReg = 0;
    logic [3:0]  MEMWBrd = '0;
    logic [15:0] MEMWBwb_data = '0;
    logic        mem_ack = 0;
    logic [15:0] mem_rdata = '0;

    logic        mem_req, mem_we, stall;
    logic [15:0] mem_addr, mem_wdata, alu_out, dmem_out, pc;
    logic [3:0]  rd;
    logic        RegDst, Branch, MemtoReg, ALUSrc, RegWrite, BranchReg, PCS, HLT, LB;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .EXMEMalu_out(EXMEMalu_out), .EXMEMstore_data(EXMEMstore_data), .EXMEMrt(EXMEMrt),
        .EXMEMrd(EXMEMrd), .EXMEMpc(EXMEMpc), .EXMEMMemRead(EXMEMMemRead),
        .EXMEMMemWrite(EXMEMMemWrite), .EXMEMRegDst(EXMEMRegDst), .EXMEMBranch(EXMEMBranch),
        .EXMEMMemtoReg(EXMEMMemtoReg), .EXMEMALUSrc(EXMEMALUSrc), .EXMEMRegWrite(EXMEMRegWrite),
        .EXMEMBranchReg(EXMEMBranchReg), .EXMEMPCS(EXMEMPCS), .EXMEMHLT(EXMEMHLT), .EXMEMLB(EXMEMLB),
        .MEMWBRegWrite(MEMWBRegWrite), .MEMWBMemtoReg(MEMWBMemtoReg), .MEMWBrd(MEMWBrd),
        .MEMWBwb_data(MEMWBwb_data), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall(stall), .alu_out(alu_out), .dmem_out(dmem_out), .pc(pc), .rd(rd),
        .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .BranchReg(BranchReg), .PCS(PCS), .HLT(HLT), .LB(LB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_nop();
        EXMEMMemRead = 0; EXMEMMemWrite = 0; EXMEMRegWrite = 0; EXMEMMemtoReg = 0;
        EXMEMLB = 0; EXMEMHLT = 0; EXMEMBranch = 0; EXMEMBranchReg = 0; EXMEMPCS = 0;
        EXMEMalu_out = '0; EXMEMstore_data = '0; EXMEMrt = '0;
    endtask

    // Bounded wait for the stage to release stall; an expired budget is a miscompare.
    task automatic wait_release(input string tag);
        for (int i = 0; i < 20 && stall; i++) tick();
        settle();
        chk(tag, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_req", {31'd0, mem_req}, 0);
        chk("rst_we", {31'd0, mem_we}, 0);
        chk("rst_addr", {16'd0, mem_addr}, 0);
        chk("rst_wdata", {16'd0, mem_wdata}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_dmem", {16'd0, dmem_out}, 0);
        rst = 1'b1;

        // ALU op passes straight through
        tick();
        EXMEMalu_out = 16'h1234; EXMEMRegWrite = 1; EXMEMpc = 16'h0102; EXMEMrd = 4'd7;
        settle();
        chk("alu_out", {16'd0, alu_out}, 32'h1234);
        chk("alu_regwrite", {31'd0, RegWrite}, 1);
        chk("alu_stall", {31'd0, stall}, 0);
        chk("alu_rd", {28'd0, rd}, 7);
        tick(); settle();
        chk("alu_req", {31'd0, mem_req}, 0);

        // LW 0x0040, ack in cycle 1
        tick();
        set_nop();
        EXMEMMemRead = 1; EXMEMMemtoReg = 1; EXMEMRegWrite = 1; EXMEMLB = 1; EXMEMalu_out = 16'h0040;
        exp_q.push_back(16'hBEEF);
        settle();
        chk("lw_c0_stall", {31'd0, stall}, 1);
        chk("lw_c0_req", {31'd0, mem_req}, 0);
        chk("lw_c0_bubble", {29'd0, RegWrite, MemtoReg, LB}, 0);
        tick();
        mem_ack = 1; mem_rdata = 16'hBEEF;
        settle();
        chk("lw_c1_req", {31'd0, mem_req}, 1);
        chk("lw_c1_addr", {16'd0, mem_addr}, 32'h0040);
        chk("lw_c1_we", {31'd0, mem_we}, 0);
        chk("lw_c1_stall", {31'd0, stall}, 1);
        tick();
        mem_ack = 0; mem_rdata = '0;
        settle();
        chk("lw_c2_stall", {31'd0, stall}, 0);
        chk("lw_c2_req", {31'd0, mem_req}, 0);
        exp_v = exp_q.pop_front();
        chk("lw_c2_dmem", {16'd0, dmem_out}, {16'd0, exp_v});
        chk("lw_c2_ctrl", {29'd0, RegWrite, MemtoReg, LB}, 32'h7);
        tick();
        set_nop();
        settle();
        chk("lw_c3_dmem", {16'd0, dmem_out}, 0);

        // SW 0x0010 data 0x00AA, ack in cycle 5
        tick();
        EXMEMMemWrite = 1; EXMEMalu_out = 16'h0010; EXMEMstore_data = 16'h00AA; EXMEMrt = 4'd5;
        EXMEMHLT = 1;
        exp_q.push_back(16'h0000);
        settle();
        chk("sw_c0_regwrite", {31'd0, RegWrite}, 0);
        chk("sw_c0_hlt", {31'd0, HLT}, 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            mem_ack = (c == 5);
            mem_rdata = 16'hFFFF;
            settle();
            chk($sformatf("sw_c%0d_we", c), {31'd0, mem_we}, 1);
            chk($sformatf("sw_c%0d_addr", c), {16'd0, mem_addr}, 32'h0010);
            chk($sformatf("sw_c%0d_wdata", c), {16'd0, mem_wdata}, 32'h00AA);
            chk($sformatf("sw_c%0d_stall_rw", c), {30'd0, stall, RegWrite}, 32'h2);
        end
        tick();
        mem_ack = 0;
        settle();
        chk("sw_c6_stall", {31'd0, stall}, 0);
        chk("sw_c6_we", {31'd0, mem_we}, 0);
        exp_v = exp_q.pop_front();
        chk("sw_c6_dmem", {16'd0, dmem_out}, {16'd0, exp_v});
        chk("sw_c6_hlt", {31'd0, HLT}, 1);
        tick();
        set_nop();

        // SW forwarded from a load in MEM/WB
        MEMWBRegWrite = 1; MEMWBMemtoReg = 1; MEMWBrd = 4'd3; MEMWBwb_data = 16'h5A5A;
        EXMEMMemWrite = 1; EXMEMrt = 4'd3; EXMEMstore_data = 16'h0000; EXMEMalu_out = 16'h0020;
        exp_q.push_back(16'h0000);
        tick();
        MEMWBRegWrite = 0; MEMWBMemtoReg = 0; MEMWBwb_data = 16'h0000;
        settle();
        chk("fwd_c1_wdata", {16'd0, mem_wdata}, 32'h5A5A);
        tick();
        mem_ack = 1;
        settle();
        chk("fwd_c2_wdata_held", {16'd0, mem_wdata}, 32'h5A5A);
        tick();
        mem_ack = 0;
        wait_release("fwd_release");
        exp_v = exp_q.pop_front();
        chk("fwd_dmem", {16'd0, dmem_out}, {16'd0, exp_v});
        tick();
        set_nop();

        // rt = r0 is never forwarded
        MEMWBRegWrite = 1; MEMWBMemtoReg = 1; MEMWBrd = 4'd0; MEMWBwb_data = 16'h5A5A;
        EXMEMMemWrite = 1; EXMEMrt = 4'd0; EXMEMstore_data = 16'h1111; EXMEMalu_out = 16'h0022;
        tick();
        mem_ack = 1;
        settle();
        chk("r0_wdata", {16'd0, mem_wdata}, 32'h1111);
        tick();
        mem_ack = 0;
        MEMWBRegWrite = 0; MEMWBMemtoReg = 0;
        wait_release("r0_release");
        tick();
        set_nop();

        // Reset during a BUSY read, then a late ack
        EXMEMMemRead = 1; EXMEMRegWrite = 1; EXMEMMemtoReg = 1; EXMEMalu_out = 16'h0080;
        tick();
        settle();
        chk("rstmid_c1_req", {31'd0, mem_req}, 1);
        tick();
        rst = 0;
        set_nop();
        settle();
        chk("rstmid_req_drop", {31'd0, mem_req}, 0);
        chk("rstmid_stall", {31'd0, stall}, 0);
        tick();
        rst = 1;
        mem_ack = 1; mem_rdata = 16'hDEAD;
        settle();
        chk("rstmid_ack_stall", {31'd0, stall}, 0);
        chk("rstmid_ack_dmem", {16'd0, dmem_out}, 0);
        tick();
        mem_ack = 0;
        settle();
        chk("rstmid_after_dmem", {16'd0, dmem_out}, 0);
        chk("rstmid_after_req", {31'd0, mem_req}, 0);

        // Spurious ack in IDLE with a non-memory op
        tick();
        EXMEMRegWrite = 1; EXMEMalu_out = 16'h4321;
        mem_ack = 1; mem_rdata = 16'hFFFF;
        settle();
        chk("spur_stall", {31'd0, stall}, 0);
        chk("spur_dmem", {16'd0, dmem_out}, 0);
        tick();
        mem_ack = 0;
        settle();
        chk("spur_next_dmem", {16'd0, dmem_out}, 0);
        chk("spur_next_stall_req", {30'd0, stall, mem_req}, 0);

        // Back-to-back loads: second launches from IDLE after DONE
        tick();
        set_nop();
        EXMEMMemRead = 1; EXMEMRegWrite = 1; EXMEMalu_out = 16'h0100;
        exp_q.push_back(16'h1357);
        tick();
        mem_ack = 1; mem_rdata = 16'h1357;
        tick();
        mem_ack = 0;
        wait_release("b2b_a_release");
        exp_v = exp_q.pop_front();
        chk("b2b_a_dmem", {16'd0, dmem_out}, {16'd0, exp_v});
        tick();
        EXMEMalu_out = 16'h0102;
        exp_q.push_back(16'h2468);
        settle();
        chk("b2b_b_c0_stall_req", {30'd0, stall, mem_req}, 32'h2);
        tick();
        mem_ack = 1; mem_rdata = 16'h2468;
        settle();
        chk("b2b_b_addr", {16'd0, mem_addr}, 32'h0102);
        tick();
        mem_ack = 0;
        wait_release("b2b_b_release");
        exp_v = exp_q.pop_front();
        chk("b2b_b_dmem", {16'd0, dmem_out}, {16'd0, exp_v});
        tick();
        set_nop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
